// File: rtl/vga_fb_port_arbiter.sv
// ============================================================================
// Module      : vga_fb_port_arbiter
// Description : Shares one framebuffer BRAM port between VGA scan-out (priority
//               inside the active window) and a CPU valid/ready requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_port_arbiter #(
  parameter int WIDTH        = 400,
  parameter int HEIGHT       = 300,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic        vga_clk,
  input  logic        vga_rst_n,
  input  logic [9:0]  vga_h_addr,
  input  logic [9:0]  vga_v_addr,
  output logic [31:0] vga_data,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_rvalid,
  input  logic        cpu_rready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_starve,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_din,
  output logic        bram_clk,
  output logic        bram_rst,
  input  logic [31:0] bram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CAP  = 2'd1,
    RD_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] C_WIDTH  = 32'(WIDTH);
  localparam logic [31:0] C_HEIGHT = 32'(HEIGHT);
  localparam logic [15:0] C_LIMIT  = 16'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        scan_valid_q, scan_valid_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;
  logic        starve_q, starve_d;

  logic [31:0] w_h_ext, w_v_ext, w_scan_addr;
  logic        w_scan_req, w_accept, w_stall;

  assign w_h_ext     = {22'd0, vga_h_addr};
  assign w_v_ext     = {22'd0, vga_v_addr};
  assign w_scan_req  = (w_h_ext < C_WIDTH) && (w_v_ext < C_HEIGHT);
  // Full 32-bit word index before the byte shift so large windows never wrap early.
  assign w_scan_addr = (w_v_ext * C_WIDTH + w_h_ext) << 2;

  assign w_accept  = cpu_valid & ~w_scan_req & (state_q == IDLE);
  assign w_stall   = cpu_valid & ~w_accept;
  assign cpu_ready = w_accept;

  assign bram_clk = vga_clk;
  assign bram_rst = ~vga_rst_n;

  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 4'd0;
    bram_addr = 32'd0;
    bram_din  = 32'd0;
    if (w_scan_req) begin
      bram_en   = 1'b1;
      bram_addr = w_scan_addr;
    end else if (w_accept) begin
      bram_en   = 1'b1;
      bram_addr = cpu_addr;
      bram_din  = cpu_wdata;
      bram_we   = cpu_wen ? cpu_wstrb : 4'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (w_accept && !cpu_wen) state_d = RD_CAP;
      end
      RD_CAP: begin
        // bram_dout here is the CPU read issued last cycle, even if scan starts now.
        rdata_d  = bram_dout;
        rvalid_d = 1'b1;
        state_d  = RD_HOLD;
      end
      RD_HOLD: begin
        if (cpu_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        rvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    scan_valid_d = w_scan_req;
    starve_cnt_d = 16'd0;
    if (w_stall) begin
      starve_cnt_d = (starve_cnt_q >= C_LIMIT) ? starve_cnt_q : starve_cnt_q + 16'd1;
    end
    starve_d = starve_q | (starve_cnt_d >= C_LIMIT);
  end

  always_ff @(posedge vga_clk) begin
    if (!vga_rst_n) begin
      state_q      <= IDLE;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      scan_valid_q <= 1'b0;
      starve_cnt_q <= 16'd0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      scan_valid_q <= scan_valid_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign vga_data   = scan_valid_q ? bram_dout : 32'd0;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_starve = starve_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_port_arbiter.sv
// ============================================================================
// Module      : tb_vga_fb_port_arbiter
// Description : Directed self-checking bench for vga_fb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_port_arbiter;

  logic        vga_clk = 1'b0;
  logic        vga_rst_n;
  logic [9:0]  vga_h_addr, vga_v_addr;
  logic [31:0] vga_data;
  logic        cpu_valid, cpu_ready, cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_rvalid, cpu_rready;
  logic [31:0] cpu_rdata;
  logic        cpu_starve;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_din;
  logic        bram_clk, bram_rst;
  logic [31:0] bram_dout;

  int errors = 0;
  int checks = 0;

  always #5 vga_clk = ~vga_clk;

  vga_fb_port_arbiter #(
    .WIDTH(400), .HEIGHT(300), .STARVE_LIMIT(8)
  ) dut (
    .vga_clk(vga_clk), .vga_rst_n(vga_rst_n),
    .vga_h_addr(vga_h_addr), .vga_v_addr(vga_v_addr), .vga_data(vga_data),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rvalid(cpu_rvalid), .cpu_rready(cpu_rready), .cpu_rdata(cpu_rdata),
    .cpu_starve(cpu_starve),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_dout(bram_dout)
  );

  // Advance one rising edge, then settle at the following negative edge.
  task automatic step();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic blank_idle();
    vga_h_addr = 10'd500; vga_v_addr = 10'd10;
    cpu_valid = 1'b0; cpu_wen = 1'b0; cpu_rready = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_wstrb = 4'd0;
  endtask

  task automatic test_reset();
    vga_rst_n = 1'b0; bram_dout = 32'hAAAA_5555;
    blank_idle();
    step(); step();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    checks++; if (cpu_starve !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b want 0", cpu_starve); end
    checks++; if (vga_data !== 32'd0) begin errors++; $display("FAIL reset_vga_data: got %h want 0", vga_data); end
    checks++; if (bram_rst !== 1'b1) begin errors++; $display("FAIL reset_bram_rst: got %b want 1", bram_rst); end
    vga_rst_n = 1'b1;
    #1;
    checks++; if (bram_rst !== 1'b0) begin errors++; $display("FAIL release_bram_rst: got %b want 0", bram_rst); end
    step();
  endtask

  task automatic test_scan();
    vga_h_addr = 10'd0; vga_v_addr = 10'd0; bram_dout = 32'h1111_2222;
    #1;
    checks++; if (bram_en !== 1'b1) begin errors++; $display("FAIL scan00_en: got %b want 1", bram_en); end
    checks++; if (bram_addr !== 32'd0) begin errors++; $display("FAIL scan00_addr: got %h want 0", bram_addr); end
    checks++; if (bram_we !== 4'd0) begin errors++; $display("FAIL scan00_we: got %h want 0", bram_we); end
    step();
    vga_h_addr = 10'd399; vga_v_addr = 10'd299; bram_dout = 32'hCAFE_F00D;
    #1;
    checks++; if (vga_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL scan_vga_data: got %h want cafef00d", vga_data); end
    checks++; if (bram_addr !== 32'h0007_52FC) begin errors++; $display("FAIL scan_last_addr: got %h want 000752fc", bram_addr); end
    step();
    vga_h_addr = 10'd400; vga_v_addr = 10'd299;
    #1;
    checks++; if (bram_en !== 1'b0) begin errors++; $display("FAIL scan_edge_en: got %b want 0", bram_en); end
    step();
    #1;
    checks++; if (vga_data !== 32'd0) begin errors++; $display("FAIL blank_vga_data: got %h want 0", vga_data); end
    blank_idle();
    step();
  endtask

  task automatic test_write();
    cpu_valid = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h10;
    cpu_wdata = 32'hDEAD_BEEF; cpu_wstrb = 4'hF;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", cpu_ready); end
    checks++; if (bram_we !== 4'hF) begin errors++; $display("FAIL wr_we: got %h want f", bram_we); end
    checks++; if (bram_addr !== 32'h10) begin errors++; $display("FAIL wr_addr: got %h want 10", bram_addr); end
    checks++; if (bram_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_din: got %h want deadbeef", bram_din); end
    step();
    cpu_addr = 32'h14; cpu_wstrb = 4'h3;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr2_ready: got %b want 1", cpu_ready); end
    checks++; if (bram_we !== 4'h3) begin errors++; $display("FAIL wr2_we: got %h want 3", bram_we); end
    step();
    blank_idle();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (bram_en !== 1'b0) begin errors++; $display("FAIL idle_en: got %b want 0", bram_en); end
  endtask

  task automatic test_read_hold();
    cpu_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h20; bram_dout = 32'h0;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", cpu_ready); end
    checks++; if (bram_we !== 4'd0 || bram_en !== 1'b1) begin errors++; $display("FAIL rd_port: got en=%b we=%h want en=1 we=0", bram_en, bram_we); end
    step();
    // Second request waits behind the outstanding read.
    cpu_wen = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h0BAD_F00D; cpu_wstrb = 4'hF;
    bram_dout = 32'h1234_5678;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rdcap_ready: got %b want 0", cpu_ready); end
    checks++; if (vga_data !== 32'd0) begin errors++; $display("FAIL rd_no_leak: got %h want 0", vga_data); end
    step();
    bram_dout = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678 || cpu_ready !== 1'b0)
        begin errors++; $display("FAIL rdhold_%0d: got rvalid=%b rdata=%h ready=%b want 1 12345678 0", i, cpu_rvalid, cpu_rdata, cpu_ready); end
      step();
    end
    cpu_rready = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rready_cycle_ready: got %b want 0", cpu_ready); end
    step();
    cpu_rready = 1'b0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_done_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rd_next_ready: got %b want 1", cpu_ready); end
    checks++; if (cpu_starve !== 1'b0) begin errors++; $display("FAIL rd_starve_below: got %b want 0", cpu_starve); end
    step();
    blank_idle();
  endtask

  task automatic test_scan_stall();
    vga_h_addr = 10'd5; vga_v_addr = 10'd5;
    cpu_valid = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h1; cpu_wstrb = 4'hF;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", cpu_ready); end
    checks++; if (bram_addr !== 32'h1F54) begin errors++; $display("FAIL stall_scan_addr: got %h want 1f54", bram_addr); end
    checks++; if (bram_we !== 4'd0) begin errors++; $display("FAIL stall_we: got %h want 0", bram_we); end
    step();
    vga_h_addr = 10'd400;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL stall_accept: got %b want 1", cpu_ready); end
    checks++; if (bram_addr !== 32'h80 || bram_we !== 4'hF) begin errors++; $display("FAIL stall_cpu_port: got addr=%h we=%h want 80 f", bram_addr, bram_we); end
    step();
    blank_idle();
    step();
  endtask

  task automatic test_starve();
    cpu_valid = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h100; cpu_wstrb = 4'hF;
    vga_v_addr = 10'd0;
    for (int i = 0; i < 8; i++) begin
      vga_h_addr = 10'(i);
      #1;
      checks++; if (cpu_starve !== 1'b0) begin errors++; $display("FAIL starve_early_%0d: got %b want 0", i, cpu_starve); end
      step();
    end
    #1;
    checks++; if (cpu_starve !== 1'b1) begin errors++; $display("FAIL starve_set: got %b want 1", cpu_starve); end
    vga_h_addr = 10'd500;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL starve_accept: got %b want 1", cpu_ready); end
    step();
    blank_idle();
    step();
    #1;
    checks++; if (cpu_starve !== 1'b1) begin errors++; $display("FAIL starve_sticky: got %b want 1", cpu_starve); end
    vga_rst_n = 1'b0;
    step();
    vga_rst_n = 1'b1;
    #1;
    checks++; if (cpu_starve !== 1'b0) begin errors++; $display("FAIL starve_cleared: got %b want 0", cpu_starve); end
    step();
  endtask

  task automatic test_reset_mid_read();
    cpu_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h30;
    step();
    cpu_valid = 1'b0; bram_dout = 32'h55AA_55AA;
    step();
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL mid_hold: got rvalid=%b rdata=%h want 1 55aa55aa", cpu_rvalid, cpu_rdata); end
    vga_rst_n = 1'b0; vga_h_addr = 10'd0; vga_v_addr = 10'd0;
    #1;
    checks++; if (bram_en !== 1'b1) begin errors++; $display("FAIL rst_comb_en: got %b want 1", bram_en); end
    step();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid: got %b want 0", cpu_rvalid); end
    checks++; if (vga_data !== 32'd0) begin errors++; $display("FAIL mid_rst_vga_data: got %h want 0", vga_data); end
    vga_rst_n = 1'b1;
    blank_idle();
    cpu_valid = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h34; cpu_wstrb = 4'h1;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b want 1", cpu_ready); end
    step();
    blank_idle();
    step();
  endtask

  initial begin
    @(negedge vga_clk);
    test_reset();
    test_scan();
    test_write();
    test_read_hold();
    test_scan_stall();
    test_starve();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
